in_packet_ctrl: RTL

//  Bulk IN endpoint transaction controller, downstream of the IN FIFO and upstream of the SIE byte transmitter.
//  On each IN token it drives the FIFO handshake and emits one response byte stream to the transmitter.
//  The response is either a DATA0/DATA1 packet (PID, payload, CRC16) or a NAK when no data is pending.
//  It tracks the data toggle and commits or rewinds FIFO data on ACK or timeout.

---
 rtl/in_packet_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/in_packet_ctrl.sv
// rtl/in_packet_ctrl.sv - bulk IN endpoint transaction controller
//
// Serves IN tokens from the IN FIFO. Each token produces either a DATA0/DATA1
// packet (PID, payload, CRC16) or a NAK. The controller tracks the data toggle
// and commits or rewinds the FIFO when the handshake arrives or times out.
//
// Optional feature macro: IN_PKT_ZLP_EN. When defined, an ACKed packet of
// exactly IN_MAXPACKETSIZE bytes arms a flag. The next token that finds the
// FIFO empty then gets a zero-length DATAx instead of a NAK.
//
// Ports:
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   clk_gate_i            one-clock enable per bit period; all state moves on it
//   token_in_i            IN token for this endpoint
//   hs_ack_i              host ACK
//   hs_timeout_i          handshake timeout
//   bus_reset_i           bus reset / endpoint clear (toggle -> DATA0)
//   fifo_data_i           byte at FIFO head
//   fifo_valid_i          FIFO head valid
//   fifo_ready_o          FIFO strobe, one gate period wide
//   fifo_req_o            with fifo_ready_o: rewind
//   fifo_data_ack_o       with fifo_ready_o: commit
//   tx_data_o             byte to transmitter
//   tx_valid_o            tx_data_o valid
//   tx_last_o             last byte of packet
//   tx_ready_i            transmitter accepts on clk_gate_i
//   busy_o                transaction in progress
`timescale 1ns/1ps
module in_packet_ctrl #(
  parameter int IN_MAXPACKETSIZE = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_gate_i,
  input  logic       token_in_i,
  input  logic       hs_ack_i,
  input  logic       hs_timeout_i,
  input  logic       bus_reset_i,
  input  logic [7:0] fifo_data_i,
  input  logic       fifo_valid_i,
  output logic       fifo_ready_o,
  output logic       fifo_req_o,
  output logic       fifo_data_ack_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  output logic       tx_last_o,
  input  logic       tx_ready_i,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(IN_MAXPACKETSIZE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(IN_MAXPACKETSIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_NAK, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_WAIT_HS
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      crc_q, crc_d;
  logic             tog_q, tog_d;
  logic             strb_d, req_d, ack_d;
`ifdef IN_PKT_ZLP_EN
  logic             zlp_q, zlp_d;
`endif

  // Reflected CRC16 (poly 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    tog_d      = tog_q;
    strb_d     = 1'b0;
    req_d      = 1'b0;
    ack_d      = 1'b0;
    tx_data_o  = 8'h00;
    tx_valid_o = 1'b0;
    tx_last_o  = 1'b0;
`ifdef IN_PKT_ZLP_EN
    zlp_d      = zlp_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (token_in_i) begin
          if (fifo_valid_i) state_d = S_PID;
`ifdef IN_PKT_ZLP_EN
          // A zero-length packet is a normal packet whose DATA phase
          // finds the FIFO empty, so the CRC comes out as 00 00.
          else if (zlp_q) state_d = S_PID;
`endif
          else state_d = S_NAK;
        end
      end
      S_NAK: begin
        tx_data_o  = 8'h5A;
        tx_valid_o = 1'b1;
        tx_last_o  = 1'b1;
        if (tx_ready_i) state_d = S_IDLE;
      end
      S_PID: begin
        tx_data_o  = tog_q ? 8'h4B : 8'hC3;
        tx_valid_o = 1'b1;
        if (tx_ready_i) begin
          state_d = S_DATA;
          cnt_d   = '0;
          crc_d   = 16'hFFFF;
        end
      end
      S_DATA: begin
        // While a consume strobe is out the FIFO head still shows the byte
        // just sent; wait one gate period for it to advance.
        if (!fifo_ready_o) begin
          if (fifo_valid_i && (cnt_q < MAX_CNT)) begin
            tx_data_o  = fifo_data_i;
            tx_valid_o = 1'b1;
            if (tx_ready_i) begin
              strb_d = 1'b1;
              crc_d  = crc16_byte(crc_q, fifo_data_i);
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_CRC_LO;
          end
        end
      end
      S_CRC_LO: begin
        tx_data_o  = ~crc_q[7:0];
        tx_valid_o = 1'b1;
        if (tx_ready_i) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_data_o  = ~crc_q[15:8];
        tx_valid_o = 1'b1;
        tx_last_o  = 1'b1;
        if (tx_ready_i) state_d = S_WAIT_HS;
      end
      S_WAIT_HS: begin
        if (hs_ack_i) begin
          strb_d  = 1'b1;
          ack_d   = 1'b1;
          tog_d   = ~tog_q;
          state_d = S_IDLE;
`ifdef IN_PKT_ZLP_EN
          zlp_d   = (cnt_q == MAX_CNT);
`endif
        end else if (hs_timeout_i || token_in_i) begin
          strb_d  = 1'b1;
          req_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus_reset_i) begin
      state_d = S_IDLE;
      tog_d   = 1'b0;
      ack_d   = 1'b0;
      req_d   = (state_q != S_IDLE) && (state_q != S_NAK);
      strb_d  = req_d;
`ifdef IN_PKT_ZLP_EN
      zlp_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      crc_q           <= 16'hFFFF;
      tog_q           <= 1'b0;
      fifo_ready_o    <= 1'b0;
      fifo_req_o      <= 1'b0;
      fifo_data_ack_o <= 1'b0;
`ifdef IN_PKT_ZLP_EN
      zlp_q           <= 1'b0;
`endif
    end else if (clk_gate_i) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      crc_q           <= crc_d;
      tog_q           <= tog_d;
      fifo_ready_o    <= strb_d;
      fifo_req_o      <= req_d;
      fifo_data_ack_o <= ack_d;
`ifdef IN_PKT_ZLP_EN
      zlp_q           <= zlp_d;
`endif
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule
